// File: rtl/rx_pkg.sv
// Shared types and constants for the receive-path session controller.
package rx_pkg;

    localparam int unsigned SeqW              = 15;
    localparam int unsigned DefaultFrameWords = 693;

    typedef logic [SeqW-1:0] seq_t;

    localparam seq_t SeqReserved = '0;
    localparam seq_t SeqMax      = '1;

    localparam logic AckCode  = 1'b0;
    localparam logic NackCode = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWaitSeq,
        StRxData,
        StCommit,
        StAck
    } rx_state_e;

    // Sequence 0 is reserved, so the counter wraps from the top back to 1.
    function automatic seq_t seq_next(input seq_t s);
        return (s == SeqMax) ? seq_t'(SeqReserved + seq_t'(1)) : s + seq_t'(1);
    endfunction

endpackage

// File: rtl/rx_bank_tracker.sv
// Busy flags for the two frame-RAM banks plus the pointer to the next bank to fill.
module rx_bank_tracker (
    input  logic       clock,
    input  logic       reset,
    input  logic       commit,
    input  logic [1:0] bank_release,
    output logic [1:0] busy,
    output logic       target
);

    logic [1:0] busy_q, busy_d;
    logic       target_q, target_d;

    // Release is applied first so a same-cycle commit to that bank overrides it.
    always_comb begin
        busy_d   = busy_q & ~bank_release;
        target_d = target_q;
        if (commit) begin
            busy_d[target_q] = 1'b1;
            target_d         = ~target_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q   <= 2'b00;
            target_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            target_q <= target_d;
        end
    end

    assign busy   = busy_q;
    assign target = target_q;

endmodule

// File: rtl/rx_session_ctrl.sv
// Session/sequencing controller: in-order frame delivery into a two-bank RAM with ACK/NACK.
module rx_session_ctrl
    import rx_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = DefaultFrameWords,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              startvalid,
    input  logic              stopvalid,
    input  logic              sequencevalid,
    input  logic [SeqW-1:0]   sequenceno,
    input  logic              checksummatch,
    input  logic              datatoRAMsof,
    input  logic              datatoRAMeof,
    input  logic              datavalid,
    input  logic [15:0]       datatoRAM,
    input  logic [1:0]        bank_release,
    input  logic              ack_grant,
    output logic              ram_we,
    output logic              ram_bank,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic              bank_ready,
    output logic              frame_bank,
    output logic [ADDR_W:0]   frame_words,
    output logic              ack_req,
    output logic              ack_nack,
    output logic [SeqW-1:0]   ack_seq,
    output logic              session_active,
    output logic              session_done,
    output logic [7:0]        drop_count
);

    localparam int unsigned     TmrW     = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] MaxWords = (ADDR_W + 1)'(FRAME_WORDS);
    localparam logic [TmrW-1:0] TmrLast  = TmrW'(TIMEOUT - 1);

    rx_state_e         state_q, state_d;
    seq_t              expected_q, expected_d;
    seq_t              seq_q, seq_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic              bad_q, bad_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic              stop_pend_q, stop_pend_d;
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic              bank_ready_q, bank_ready_d;
    logic              frame_bank_q, frame_bank_d;
    logic [ADDR_W:0]   frame_words_q, frame_words_d;
    logic              ack_req_q, ack_req_d;
    logic              ack_nack_q, ack_nack_d;
    seq_t              ack_seq_q, ack_seq_d;
    logic [7:0]        drop_q, drop_d;
    logic              ram_we_q, ram_we_d;
    logic              ram_bank_q, ram_bank_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [15:0]       ram_wdata_q, ram_wdata_d;

    logic       commit;
    logic [1:0] busy;
    logic       target;
    logic       good_start, good_stop, good_seq;
    logic       drop_inc, bad_now;

    rx_bank_tracker u_bank_tracker (
        .clock        (clock),
        .reset        (reset),
        .commit       (commit),
        .bank_release (bank_release),
        .busy         (busy),
        .target       (target)
    );

    assign good_start = startvalid & checksummatch;
    assign good_stop  = stopvalid & checksummatch;
    assign good_seq   = sequencevalid & checksummatch;

    always_comb begin
        state_d       = state_q;
        expected_d    = expected_q;
        seq_d         = seq_q;
        wcnt_d        = wcnt_q;
        bad_d         = bad_q;
        tmr_d         = tmr_q;
        stop_pend_d   = stop_pend_q;
        active_d      = active_q;
        done_d        = 1'b0;
        bank_ready_d  = 1'b0;
        frame_bank_d  = frame_bank_q;
        frame_words_d = frame_words_q;
        ack_req_d     = ack_req_q & ~ack_grant;
        ack_nack_d    = ack_nack_q;
        ack_seq_d     = ack_seq_q;
        ram_we_d      = 1'b0;
        ram_bank_d    = ram_bank_q;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        drop_d        = drop_q;
        commit        = 1'b0;
        bad_now       = bad_q;
        drop_inc      = (startvalid | stopvalid | sequencevalid) & ~checksummatch;

        unique case (state_q)
            StIdle: begin
                if (good_start) begin
                    expected_d  = seq_t'(1);
                    active_d    = 1'b1;
                    stop_pend_d = 1'b0;
                    state_d     = StWaitSeq;
                end
            end

            StWaitSeq: begin
                if (good_start) begin
                    expected_d = seq_t'(1);
                end else if (good_stop) begin
                    done_d   = 1'b1;
                    active_d = 1'b0;
                    state_d  = StIdle;
                end else if (good_seq) begin
                    if (sequenceno != expected_q) begin
                        ack_req_d  = 1'b1;
                        ack_nack_d = NackCode;
                        ack_seq_d  = expected_q;
                        state_d    = StAck;
                    end else if (busy[target]) begin
                        ack_req_d  = 1'b1;
                        ack_nack_d = NackCode;
                        ack_seq_d  = sequenceno;
                        state_d    = StAck;
                    end else begin
                        seq_d   = sequenceno;
                        wcnt_d  = '0;
                        bad_d   = 1'b0;
                        tmr_d   = '0;
                        state_d = StRxData;
                    end
                end
            end

            StRxData: begin
                if (good_start) begin
                    expected_d = seq_t'(1);
                    state_d    = StWaitSeq;
                end else if (good_stop) begin
                    done_d   = 1'b1;
                    active_d = 1'b0;
                    state_d  = StIdle;
                end else begin
                    if (datavalid) begin
                        // A second start-of-frame inside a frame means the previous eof was lost.
                        if (datatoRAMsof && wcnt_q != '0) begin
                            bad_now = 1'b1;
                        end
                        if (wcnt_q < MaxWords) begin
                            ram_we_d    = 1'b1;
                            ram_bank_d  = target;
                            ram_addr_d  = wcnt_q[ADDR_W-1:0];
                            ram_wdata_d = datatoRAM;
                            wcnt_d      = wcnt_q + 1'b1;
                        end else begin
                            bad_now = 1'b1;
                        end
                    end
                    bad_d = bad_now;
                    if (datatoRAMeof) begin
                        if (checksummatch && !bad_now) begin
                            state_d = StCommit;
                        end else begin
                            ack_req_d  = 1'b1;
                            ack_nack_d = NackCode;
                            ack_seq_d  = seq_q;
                            drop_inc   = 1'b1;
                            state_d    = StAck;
                        end
                    end else if (tmr_q == TmrLast) begin
                        ack_req_d  = 1'b1;
                        ack_nack_d = NackCode;
                        ack_seq_d  = seq_q;
                        state_d    = StAck;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end

            StCommit: begin
                commit        = 1'b1;
                bank_ready_d  = 1'b1;
                frame_bank_d  = target;
                frame_words_d = wcnt_q;
                expected_d    = seq_next(expected_q);
                ack_req_d     = 1'b1;
                ack_nack_d    = AckCode;
                ack_seq_d     = seq_q;
                state_d       = StAck;
                if (good_stop) begin
                    stop_pend_d = 1'b1;
                end
                if (good_start || good_seq) begin
                    drop_inc = 1'b1;
                end
            end

            StAck: begin
                if (good_start || good_seq) begin
                    drop_inc = 1'b1;
                end
                if (good_stop) begin
                    stop_pend_d = 1'b1;
                end
                if (ack_grant) begin
                    if (stop_pend_q || good_stop) begin
                        stop_pend_d = 1'b0;
                        done_d      = 1'b1;
                        active_d    = 1'b0;
                        state_d     = StIdle;
                    end else begin
                        state_d = StWaitSeq;
                    end
                end
            end

            default: state_d = StIdle;
        endcase

        if (drop_inc && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            expected_q    <= seq_t'(1);
            seq_q         <= '0;
            wcnt_q        <= '0;
            bad_q         <= 1'b0;
            tmr_q         <= '0;
            stop_pend_q   <= 1'b0;
            active_q      <= 1'b0;
            done_q        <= 1'b0;
            bank_ready_q  <= 1'b0;
            frame_bank_q  <= 1'b0;
            frame_words_q <= '0;
            ack_req_q     <= 1'b0;
            ack_nack_q    <= 1'b0;
            ack_seq_q     <= '0;
            drop_q        <= '0;
            ram_we_q      <= 1'b0;
            ram_bank_q    <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            expected_q    <= expected_d;
            seq_q         <= seq_d;
            wcnt_q        <= wcnt_d;
            bad_q         <= bad_d;
            tmr_q         <= tmr_d;
            stop_pend_q   <= stop_pend_d;
            active_q      <= active_d;
            done_q        <= done_d;
            bank_ready_q  <= bank_ready_d;
            frame_bank_q  <= frame_bank_d;
            frame_words_q <= frame_words_d;
            ack_req_q     <= ack_req_d;
            ack_nack_q    <= ack_nack_d;
            ack_seq_q     <= ack_seq_d;
            drop_q        <= drop_d;
            ram_we_q      <= ram_we_d;
            ram_bank_q    <= ram_bank_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
        end
    end

    assign ram_we         = ram_we_q;
    assign ram_bank       = ram_bank_q;
    assign ram_addr       = ram_addr_q;
    assign ram_wdata      = ram_wdata_q;
    assign bank_ready     = bank_ready_q;
    assign frame_bank     = frame_bank_q;
    assign frame_words    = frame_words_q;
    assign ack_req        = ack_req_q;
    assign ack_nack       = ack_nack_q;
    assign ack_seq        = ack_seq_q;
    assign session_active = active_q;
    assign session_done   = done_q;
    assign drop_count     = drop_q;

endmodule
